connect4_board_ctrl: RTL and testbench

//  Game-state engine for the Connect-4 board. Accepts column-drop requests, places the token at
//  the lowest empty row, checks win/draw, alternates the player. Drives the panel, play, player,

---
 rtl/connect4_board_ctrl_if.sv | 23 ++
 rtl/connect4_board_ctrl.sv | 162 ++++++++++++++++
 tb/tb_connect4_board_ctrl.sv | 246 ++++++++++++++++++++++++
 3 files changed

// File: rtl/connect4_board_ctrl_if.sv
// rtl/connect4_board_ctrl_if.sv - move handshake and board-state bus of the Connect-4 engine
interface connect4_board_ctrl_if;
   logic                  new_game;
   logic                  move_valid;
   logic [2:0]            move_col;
   logic                  move_ready;
   logic                  move_err;
   logic                  undo_req;
   logic [5:0][6:0][1:0]  panel;
   logic [6:0]            play;
   logic                  player;
   logic [1:0]            winner;

   modport master (
      output new_game, move_valid, move_col, undo_req,
      input  move_ready, move_err, panel, play, player, winner
   );

   modport slave (
      input  new_game, move_valid, move_col, undo_req,
      output move_ready, move_err, panel, play, player, winner
   );
endinterface

// File: rtl/connect4_board_ctrl.sv
// rtl/connect4_board_ctrl.sv - Connect-4 game-state engine: drop, win/draw check, player turn
// Optional one-level undo is compiled in when C4_UNDO_EN is defined.
module connect4_board_ctrl #(
   parameter logic FIRST_PLAYER    = 1'b0,
   parameter bit   ALTERNATE_START = 1'b1
) (
   input logic                  clk,
   input logic                  rst,
   connect4_board_ctrl_if.slave bus
);
   typedef enum logic [1:0] {IDLE, CHECK, OVER} state_t;

   state_t               state_q, state_d;
   logic [5:0][6:0][1:0] panel_q;
   logic [6:0]           play_q;
   logic                 player_q;
   logic                 start_q;
   logic [1:0]           winner_q;
   logic                 err_q;
   logic [5:0]           count_q;
   logic [1:0]           code;
   logic                 accept;
   logic                 drop_ok;
   logic [2:0]           drop_row;
   logic                 win;
   logic                 undo_take;

`ifdef C4_UNDO_EN
   logic [2:0] last_row, last_col;
   logic       last_mover, undo_avail;
   assign undo_take = bus.undo_req & ~bus.new_game & undo_avail &
                      ((state_q == IDLE) || (state_q == OVER));
`else
   logic unused_undo;
   assign unused_undo = bus.undo_req;
   assign undo_take   = 1'b0;
`endif

   assign code           = player_q ? 2'b10 : 2'b01;
   assign bus.move_ready = (state_q == IDLE) & ~bus.new_game & ~undo_take;
   assign accept         = bus.move_valid & bus.move_ready;

   assign bus.panel    = panel_q;
   assign bus.play     = play_q;
   assign bus.player   = player_q;
   assign bus.winner   = winner_q;
   assign bus.move_err = err_q;

   // Token lands on the accepting edge, so CHECK is the single busy cycle afterwards.
   always_comb begin
      drop_ok  = 1'b0;
      drop_row = 3'd0;
      for (int c = 0; c < 7; c++) begin
         if (bus.move_col == 3'(c)) begin
            for (int r = 5; r >= 0; r--) begin
               if (panel_q[3'(r)][3'(c)] == 2'b00) begin
                  drop_ok  = 1'b1;
                  drop_row = 3'(r);
               end
            end
         end
      end
   end

   function automatic logic line4(input int r, input int c, input int dr, input int dc);
      line4 = 1'b1;
      for (int i = 0; i < 4; i++)
         if (panel_q[3'(r + i*dr)][3'(c + i*dc)] != code) line4 = 1'b0;
   endfunction

   always_comb begin
      win = 1'b0;
      for (int r = 0; r < 6; r++) begin
         for (int c = 0; c < 7; c++) begin
            if (c < 4 && line4(r, c, 0, 1))           win = 1'b1;
            if (r < 3 && line4(r, c, 1, 0))           win = 1'b1;
            if (r < 3 && c < 4 && line4(r, c, 1, 1))  win = 1'b1;
            if (r < 3 && c > 2 && line4(r, c, 1, -1)) win = 1'b1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) state_q <= IDLE;
      else     state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (accept && drop_ok) state_d = CHECK;
         CHECK:   state_d = (win || count_q == 6'd42) ? OVER : IDLE;
         OVER:    if (undo_take) state_d = IDLE;
         default: state_d = IDLE;
      endcase
      if (bus.new_game) state_d = IDLE;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         panel_q  <= '0;
         play_q   <= '0;
         player_q <= FIRST_PLAYER;
         start_q  <= FIRST_PLAYER;
         winner_q <= 2'b00;
         err_q    <= 1'b0;
         count_q  <= '0;
`ifdef C4_UNDO_EN
         last_row   <= '0;
         last_col   <= '0;
         last_mover <= 1'b0;
         undo_avail <= 1'b0;
`endif
      end else begin
         err_q <= 1'b0;
         if (bus.new_game) begin
            panel_q  <= '0;
            play_q   <= '0;
            winner_q <= 2'b00;
            count_q  <= '0;
            if (ALTERNATE_START) begin
               start_q  <= ~start_q;
               player_q <= ~start_q;
            end else begin
               start_q  <= FIRST_PLAYER;
               player_q <= FIRST_PLAYER;
            end
`ifdef C4_UNDO_EN
            undo_avail <= 1'b0;
`endif
         end else if (accept) begin
            if (drop_ok) begin
               panel_q[drop_row][bus.move_col] <= code;
               play_q  <= 7'b0000001 << bus.move_col;
               count_q <= count_q + 6'd1;
`ifdef C4_UNDO_EN
               last_row   <= drop_row;
               last_col   <= bus.move_col;
               last_mover <= player_q;
               undo_avail <= 1'b1;
`endif
            end else begin
               err_q <= 1'b1;
            end
         end else if (state_q == CHECK) begin
            if (win)                    winner_q <= code;
            else if (count_q == 6'd42)  winner_q <= 2'b11;
            else                        player_q <= ~player_q;
         end
`ifdef C4_UNDO_EN
         else if (undo_take) begin
            panel_q[last_row][last_col] <= 2'b00;
            player_q   <= last_mover;
            play_q     <= '0;
            winner_q   <= 2'b00;
            count_q    <= count_q - 6'd1;
            undo_avail <= 1'b0;
         end
`endif
      end
   end
endmodule

// File: tb/tb_connect4_board_ctrl.sv
// tb/tb_connect4_board_ctrl.sv - scoreboard bench for connect4_board_ctrl
module tb_connect4_board_ctrl;
   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   connect4_board_ctrl_if bus();

   connect4_board_ctrl #(.FIRST_PLAYER(1'b0), .ALTERNATE_START(1'b1)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   typedef struct {
      int          at;
      logic [83:0] panel;
      logic [6:0]  play;
      logic        player;
      logic [1:0]  winner;
      logic        ready;
      logic        err;
   } exp_t;

   exp_t  q[$];
   string qn[$];
   int    cyc = 0;
   int    checks = 0;
   int    errors = 0;
   bit    done = 1'b0;
   bit    closed = 1'b0;

   logic [5:0][6:0][1:0] m_panel;
   logic [6:0]           m_play;
   logic                 m_player, m_start;
   logic [1:0]           m_winner;
   logic                 m_ready, m_err;

   always @(posedge clk) cyc++;

   always @(negedge clk) begin : monitor
      exp_t  e;
      string n;
      while (q.size() > 0 && q[0].at <= cyc) begin
         e = q.pop_front();
         n = qn.pop_front();
         checks++;
         if (e.at != cyc || bus.panel !== e.panel || bus.play !== e.play ||
             bus.player !== e.player || bus.winner !== e.winner ||
             bus.move_ready !== e.ready || bus.move_err !== e.err) begin
            errors++;
            $display("FAIL %s @%0d: got panel=%h play=%b player=%b winner=%b ready=%b err=%b, want panel=%h play=%b player=%b winner=%b ready=%b err=%b (due @%0d)",
                     n, cyc, bus.panel, bus.play, bus.player, bus.winner, bus.move_ready, bus.move_err,
                     e.panel, e.play, e.player, e.winner, e.ready, e.err, e.at);
         end
      end
      if (done && !closed) begin
         checks++;
         closed = 1'b1;
         if (q.size() != 0) begin
            errors++;
            $display("FAIL drain: %0d expectations left, want 0", q.size());
         end
      end
   end

   initial begin
      #100000;
      $display("FAIL watchdog: run did not finish by cycle %0d", cyc);
      $fatal(1);
   end

   task automatic push(input int at, input string n);
      exp_t e;
      e.at = at; e.panel = m_panel; e.play = m_play; e.player = m_player;
      e.winner = m_winner; e.ready = m_ready; e.err = m_err;
      q.push_back(e);
      qn.push_back(n);
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic model_reset();
      m_panel = '0; m_play = '0; m_player = 1'b0; m_start = 1'b0;
      m_winner = 2'b00; m_ready = 1'b1; m_err = 1'b0;
   endtask

   task automatic do_rst();
      tick();
      rst = 1'b1;
      model_reset();
      push(cyc + 1, "reset");
      tick();
      rst = 1'b0;
   endtask

   task automatic model_place(input int col);
      int r;
      r = 0;
      for (int i = 5; i >= 0; i--) if (m_panel[i][col] == 2'b00) r = i;
      m_panel[r][col] = m_player ? 2'b10 : 2'b01;
      m_play = 7'b0000001 << col;
      m_ready = 1'b0;
      m_err = 1'b0;
   endtask

   task automatic drop(input int col, input logic [1:0] win, input bit hold);
      tick();
      bus.move_valid = 1'b1;
      bus.move_col = 3'(col);
      model_place(col);
      push(cyc + 1, "place");
      m_winner = win;
      if (win == 2'b00) m_player = ~m_player;
      m_ready = (win == 2'b00);
      push(cyc + 2, "check");
      tick();
      if (hold) tick();
      bus.move_valid = 1'b0;
   endtask

   task automatic drop_bad(input int col);
      tick();
      bus.move_valid = 1'b1;
      bus.move_col = 3'(col);
      m_err = 1'b1; m_ready = 1'b1;
      push(cyc + 1, "move_err");
      m_err = 1'b0;
      push(cyc + 2, "move_err_clear");
      tick();
      bus.move_valid = 1'b0;
   endtask

   task automatic over_ignore(input int col);
      tick();
      bus.move_valid = 1'b1;
      bus.move_col = 3'(col);
      push(cyc + 1, "over_ignore");
      tick();
      bus.move_valid = 1'b0;
   endtask

   task automatic new_game(input bit with_move);
      tick();
      tick();
      bus.new_game = 1'b1;
      bus.move_valid = with_move;
      bus.move_col = 3'd3;
      m_ready = 1'b0;
      push(cyc, "ready_low_new_game");
      m_start = ~m_start; m_player = m_start;
      m_panel = '0; m_play = '0; m_winner = 2'b00; m_ready = 1'b1; m_err = 1'b0;
      push(cyc + 1, with_move ? "new_game_beats_move" : "new_game");
      tick();
      bus.new_game = 1'b0;
      bus.move_valid = 1'b0;
   endtask

   task automatic undo(input int row, input int col, input bit takes);
      tick();
      tick();
      bus.undo_req = 1'b1;
      if (takes) begin
         m_panel[row][col] = 2'b00;
         m_player = ~m_player;
         m_play = '0;
      end
      m_ready = 1'b1;
      push(cyc + 1, takes ? "undo" : "undo_ignored");
      tick();
      bus.undo_req = 1'b0;
   endtask

   task automatic rst_in_check(input int col);
      tick();
      bus.move_valid = 1'b1;
      bus.move_col = 3'(col);
      model_place(col);
      push(cyc + 1, "place_before_rst");
      model_reset();
      push(cyc + 2, "rst_in_check");
      tick();
      bus.move_valid = 1'b0;
      rst = 1'b1;
      tick();
      rst = 1'b0;
   endtask

   initial begin
      int diag_cols[12];
      int pa[3];
      int pb[3];
      diag_cols = '{1, 0, 2, 1, 2, 2, 3, 6, 3, 6, 3, 3};
      pa = '{0, 1, 4};
      pb = '{2, 3, 6};
      bus.new_game = 1'b0; bus.move_valid = 1'b0; bus.move_col = 3'd0; bus.undo_req = 1'b0;

      do_rst();
      drop(3, 2'b00, 1'b0);

      do_rst();
      drop(0, 2'b00, 1'b0); drop(1, 2'b00, 1'b0);
      drop(0, 2'b00, 1'b0); drop(1, 2'b00, 1'b0);
      drop(0, 2'b00, 1'b1); drop(1, 2'b00, 1'b0);
      drop(0, 2'b01, 1'b0);
      over_ignore(5);
      new_game(1'b0);

      for (int i = 0; i < 6; i++) drop(2, 2'b00, 1'b0);
      drop_bad(2);
      drop_bad(7);
      new_game(1'b0);

      for (int i = 0; i < 12; i++) drop(diag_cols[i], (i == 11) ? 2'b10 : 2'b00, 1'b0);
      new_game(1'b0);
      new_game(1'b1);

      for (int p = 0; p < 3; p++) begin
         for (int k = 0; k < 3; k++) begin
            drop(pa[p], 2'b00, 1'b0); drop(pb[p], 2'b00, 1'b0);
            drop(pb[p], 2'b00, 1'b0); drop(pa[p], 2'b00, 1'b0);
         end
      end
      for (int k = 0; k < 5; k++) drop(5, 2'b00, 1'b0);
      drop(5, 2'b11, 1'b0);
      new_game(1'b0);
      rst_in_check(4);

      drop(4, 2'b00, 1'b0);
`ifdef C4_UNDO_EN
      undo(0, 4, 1'b1);
      undo(0, 4, 1'b0);
`else
      undo(0, 4, 1'b0);
`endif

      repeat (3) tick();
      done = 1'b1;
      repeat (3) tick();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
